// File: rtl/clock_time_controller.sv
// Hour/min/sec timekeeping with a two-button set mode and blink masking
// for the 6-digit multiplexed displayer; everything runs on clk_1000hz.

module clock_time_debounce #(
  parameter int DEBOUNCE_CYC = 20
) (
  input  logic clk_1000hz,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync_1;
  logic          sync_2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] stable_cnt;

  always_ff @(posedge clk_1000hz) begin
    if (!rst_n) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      level      <= 1'b0;
      level_q    <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync_1  <= btn;
      sync_2  <= sync_1;
      level_q <= level;
      if (sync_2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CW'(DEBOUNCE_CYC)) begin
        level      <= sync_2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + CW'(1);
      end
    end
  end

  // only the press is of interest; releases are silently absorbed
  assign pulse = level & ~level_q;

endmodule

module clock_time_controller #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int DEBOUNCE_CYC  = 20,
  parameter int BLINK_HALF    = 250
) (
  input  logic       clk_1000hz,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [5:0] hour,
  output logic [1:0] mode,
  output logic [2:0] blank_mask
);

  // state    | meaning
  // RUN      | normal timekeeping, INC ignored
  // SET_HOUR | INC bumps hour, hour pair blinks
  // SET_MIN  | INC bumps minutes, min pair blinks
  // SET_SEC  | INC bumps seconds, sec pair blinks
  localparam logic [1:0] MODE_RUN      = 2'd0;
  localparam logic [1:0] MODE_SET_HOUR = 2'd1;
  localparam logic [1:0] MODE_SET_MIN  = 2'd2;
  localparam logic [1:0] MODE_SET_SEC  = 2'd3;

  localparam int PW = $clog2(TICKS_PER_SEC + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);

  logic          mode_pulse;
  logic          inc_pulse;
  logic [PW-1:0] presc;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  logic          tick;
  logic          inc_take;
  logic [5:0]    sec_nxt;
  logic [5:0]    min_nxt;
  logic [5:0]    hour_nxt;
  logic [1:0]    mode_nxt;
  logic [PW-1:0] presc_nxt;
  logic [BW-1:0] blink_cnt_nxt;
  logic          blink_phase_nxt;
  logic [2:0]    blank_mask_nxt;

  clock_time_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
    .clk_1000hz (clk_1000hz),
    .rst_n      (rst_n),
    .btn        (btn_mode),
    .pulse      (mode_pulse)
  );

  clock_time_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_inc (
    .clk_1000hz (clk_1000hz),
    .rst_n      (rst_n),
    .btn        (btn_inc),
    .pulse      (inc_pulse)
  );

  assign tick     = (mode == MODE_RUN) && (presc == PW'(TICKS_PER_SEC - 1));
  // a coincident MODE pulse wins, so INC is dropped in that cycle
  assign inc_take = inc_pulse && !mode_pulse && (mode != MODE_RUN);

  always_comb begin
    sec_nxt  = sec;
    min_nxt  = min;
    hour_nxt = hour;
    mode_nxt = mode;

    if (tick) begin
      if (sec == 6'd59) begin
        sec_nxt = 6'd0;
        if (min == 6'd59) begin
          min_nxt  = 6'd0;
          hour_nxt = (hour == 6'd23) ? 6'd0 : hour + 6'd1;
        end else begin
          min_nxt = min + 6'd1;
        end
      end else begin
        sec_nxt = sec + 6'd1;
      end
    end

    if (mode_pulse) begin
      mode_nxt = mode + 2'd1;
    end else if (inc_take) begin
      case (mode)
        MODE_SET_HOUR: hour_nxt = (hour == 6'd23) ? 6'd0 : hour + 6'd1;
        MODE_SET_MIN:  min_nxt  = (min  == 6'd59) ? 6'd0 : min  + 6'd1;
        MODE_SET_SEC:  sec_nxt  = (sec  == 6'd59) ? 6'd0 : sec  + 6'd1;
        default:       ;
      endcase
    end
  end

  // prescaler restarts from zero whenever RUN is (re)entered
  always_comb begin
    if ((mode != MODE_RUN) || mode_pulse || tick) begin
      presc_nxt = '0;
    end else begin
      presc_nxt = presc + PW'(1);
    end
  end

  always_comb begin
    if (mode_pulse || inc_take) begin
      blink_cnt_nxt   = '0;
      blink_phase_nxt = 1'b0;
    end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
      blink_cnt_nxt   = '0;
      blink_phase_nxt = ~blink_phase;
    end else begin
      blink_cnt_nxt   = blink_cnt + BW'(1);
      blink_phase_nxt = blink_phase;
    end
  end

  always_comb begin
    case (mode_nxt)
      MODE_SET_HOUR: blank_mask_nxt = {blink_phase_nxt, 2'b00};
      MODE_SET_MIN:  blank_mask_nxt = {1'b0, blink_phase_nxt, 1'b0};
      MODE_SET_SEC:  blank_mask_nxt = {2'b00, blink_phase_nxt};
      default:       blank_mask_nxt = 3'b000;
    endcase
  end

  always_ff @(posedge clk_1000hz) begin
    if (!rst_n) begin
      sec         <= '0;
      min         <= '0;
      hour        <= '0;
      mode        <= MODE_RUN;
      blank_mask  <= '0;
      presc       <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      sec         <= sec_nxt;
      min         <= min_nxt;
      hour        <= hour_nxt;
      mode        <= mode_nxt;
      blank_mask  <= blank_mask_nxt;
      presc       <= presc_nxt;
      blink_cnt   <= blink_cnt_nxt;
      blink_phase <= blink_phase_nxt;
    end
  end

endmodule

// File: tb/tb_clock_time_controller.sv
// Directed bench for clock_time_controller, checked every cycle against a
// seconds-of-day / elapsed-cycle model plus hand-computed literal points.

module tb_clock_time_controller;

  localparam int T = 10;
  localparam int D = 4;
  localparam int B = 3;

  logic       clk_1000hz;
  logic       rst_n;
  logic       btn_mode;
  logic       btn_inc;
  logic [5:0] sec;
  logic [5:0] min;
  logic [5:0] hour;
  logic [1:0] mode;
  logic [2:0] blank_mask;

  int total = 0;
  int bad   = 0;

  clock_time_controller #(
    .TICKS_PER_SEC (T),
    .DEBOUNCE_CYC  (D),
    .BLINK_HALF    (B)
  ) dut (
    .clk_1000hz (clk_1000hz),
    .rst_n      (rst_n),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .sec        (sec),
    .min        (min),
    .hour       (hour),
    .mode       (mode),
    .blank_mask (blank_mask)
  );

  initial begin
    clk_1000hz = 1'b0;
    forever #5 clk_1000hz = ~clk_1000hz;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // model: time as seconds-of-day, blink/prescale as elapsed cycles
  int m_secs, m_mode, m_run, m_blink;
  int m_h1[2], m_h2[2], m_lvl[2], m_len[2], m_rose[2];
  bit m_valid = 1'b0;

  function automatic int m_field(input int which);
    case (which)
      0: return m_secs % 60;
      1: return (m_secs / 60) % 60;
      default: return m_secs / 3600;
    endcase
  endfunction

  function automatic int m_mask();
    if (m_mode == 0) return 0;
    return ((m_blink / B) % 2) << (3 - m_mode);
  endfunction

  always @(posedge clk_1000hz) begin : model
    int raw[2];
    int pls[2];
    int hh, mm, ss;
    raw[0] = int'(btn_mode);
    raw[1] = int'(btn_inc);
    if (!rst_n) begin
      m_secs = 0; m_mode = 0; m_run = 0; m_blink = 0;
      for (int b = 0; b < 2; b++) begin
        m_h1[b] = 0; m_h2[b] = 0; m_lvl[b] = 0; m_len[b] = 0; m_rose[b] = 0;
      end
      m_valid = 1'b1;
    end else begin
      for (int b = 0; b < 2; b++) begin
        pls[b] = m_rose[b];
        m_rose[b] = 0;
        if (m_h2[b] != m_lvl[b]) begin
          m_len[b]++;
          if (m_len[b] == D + 1) begin
            m_lvl[b]  = m_h2[b];
            m_len[b]  = 0;
            m_rose[b] = m_lvl[b];
          end
        end else begin
          m_len[b] = 0;
        end
        m_h2[b] = m_h1[b];
        m_h1[b] = raw[b];
      end
      if (m_mode == 0) begin
        m_run++;
        if (m_run % T == 0) m_secs = (m_secs + 1) % 86400;
      end
      if (pls[0] != 0) begin
        m_mode  = (m_mode + 1) % 4;
        m_run   = 0;
        m_blink = 0;
      end else if (pls[1] != 0 && m_mode != 0) begin
        hh = m_secs / 3600; mm = (m_secs / 60) % 60; ss = m_secs % 60;
        if (m_mode == 1) hh = (hh + 1) % 24;
        if (m_mode == 2) mm = (mm + 1) % 60;
        if (m_mode == 3) ss = (ss + 1) % 60;
        m_secs  = hh * 3600 + mm * 60 + ss;
        m_blink = 0;
      end else begin
        m_blink = (m_blink + 1) % (2 * B);
      end
    end
  end

  always @(negedge clk_1000hz) begin
    if (m_valid) begin
      chk("sec", int'(sec), m_field(0));
      chk("min", int'(min), m_field(1));
      chk("hour", int'(hour), m_field(2));
      chk("mode", int'(mode), m_mode);
      chk("blank_mask", int'(blank_mask), m_mask());
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_1000hz);
  endtask

  // which: 0 = MODE, 1 = INC, 2 = both together
  task automatic press(input int which, input int len);
    if (which != 1) btn_mode = 1'b1;
    if (which != 0) btn_inc  = 1'b1;
    idle(len);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic tap(input int which);
    press(which, 8);
    idle(8);
  endtask

  task automatic set_field(input int which, input int target, input int modulus);
    int n;
    n = (target - m_field(which) + modulus) % modulus;
    for (int i = 0; i < n; i++) tap(1);
  endtask

  initial begin
    int hexp[3];
    hexp = '{23, 0, 1};
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    rst_n    = 1'b0;
    idle(2);
    chk("reset_sec", int'(sec), 0);
    chk("reset_hour", int'(hour), 0);
    chk("reset_mode", int'(mode), 0);
    chk("reset_mask", int'(blank_mask), 0);
    rst_n = 1'b1;

    idle(100);
    chk("run100_sec", int'(sec), 10);
    chk("run100_min", int'(min), 0);
    chk("run100_hour", int'(hour), 0);
    chk("run100_mask", int'(blank_mask), 0);

    press(0, 3);
    idle(15);
    chk("glitch_mode", int'(mode), 0);

    btn_mode = 1'b1;
    idle(7);
    chk("mode_before_edge7", int'(mode), 0);
    idle(1);
    chk("mode_after_edge7", int'(mode), 1);
    btn_mode = 1'b0;
    idle(20);
    chk("single_transition", int'(mode), 1);

    set_field(2, 23, 24);
    tap(0);
    set_field(1, 59, 60);
    tap(0);
    set_field(0, 59, 60);
    press(0, 8);
    chk("preload_mode", int'(mode), 0);
    chk("preload_hour", int'(hour), 23);
    chk("preload_min", int'(min), 59);
    chk("preload_sec", int'(sec), 59);
    idle(9);
    chk("wrap_pending_sec", int'(sec), 59);
    idle(1);
    chk("wrap_sec", int'(sec), 0);
    chk("wrap_min", int'(min), 0);
    chk("wrap_hour", int'(hour), 0);
    idle(8);

    tap(0);
    set_field(2, 22, 24);
    for (int k = 0; k < 3; k++) begin
      press(1, 8);
      chk("inc_hour", int'(hour), hexp[k]);
      chk("inc_mask_p0", int'(blank_mask), 0);
      idle(2);
      chk("inc_mask_p2", int'(blank_mask), 0);
      idle(1);
      chk("inc_mask_p3", int'(blank_mask), 4);
      idle(5);
    end

    tap(0);
    set_field(1, 5, 60);
    press(2, 8);
    chk("both_mode", int'(mode), 3);
    chk("both_min", int'(min), 5);
    chk("both_mask", int'(blank_mask), 0);
    idle(8);

    btn_mode = 1'b1;
    idle(4);
    rst_n = 1'b0;
    idle(1);
    chk("midreset_sec", int'(sec), 0);
    chk("midreset_min", int'(min), 0);
    chk("midreset_hour", int'(hour), 0);
    chk("midreset_mode", int'(mode), 0);
    chk("midreset_mask", int'(blank_mask), 0);
    rst_n = 1'b1;
    idle(7);
    chk("redebounce_early", int'(mode), 0);
    idle(1);
    chk("redebounce_done", int'(mode), 1);
    btn_mode = 1'b0;
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_time_controller.md
Name: clock_time_controller

Overview:
- Owns the hour/min/sec state of the clock and drives the existing 6-digit multiplexed displayer.
- Sequences normal timekeeping from the 1000 Hz system clock.
- Provides a two-button set mode: debounced MODE and INC buttons, with blink masking of the field being edited.
- The displayer ANDs its digit enables with ~blank_mask. The displayer itself is unchanged apart from that gating.

Parameters:
- TICKS_PER_SEC, 1000: clk_1000hz cycles per second tick.
- DEBOUNCE_CYC, 20: consecutive stable cycles required before a button level is accepted.
- BLINK_HALF, 250: cycles per blink half-period (250 gives 2 Hz blink).

Ports:
- clk_1000hz  in  1  sole clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- btn_mode  in  1  raw MODE button, active-high, asynchronous to clock.
- btn_inc  in  1  raw INC button, active-high, asynchronous to clock.
- sec  out  6  seconds, 0..59, registered.
- min  out  6  minutes, 0..59, registered.
- hour  out  6  hours, 0..23, registered.
- mode  out  2  0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=SET_SEC.
- blank_mask  out  3  bit0=sec pair, bit1=min pair, bit2=hour pair; 1 blanks that pair.

Behaviour:
- Interface: one clock, clk_1000hz. Reset rst_n is synchronous and active-low.
- Reset values (rst_n low at a posedge; takes effect at that edge, including mid-operation):
  - sec=min=hour=0, mode=RUN, blank_mask=0.
  - Prescaler=0, blink counter=0, blink phase=0.
  - Synchronizers=0, debounced levels=0, debounce counters=0.
- Button path, per button:
  - 2-flop synchronizer.
  - Debounce counter increments while the synced value differs from the debounced level, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYC, the debounced level takes the synced value and the counter clears.
  - A rising edge of the debounced level produces a one-cycle internal pulse. Falling edges produce nothing.
- Latency: the raw input is first sampled high at edge 0. The debounced level rises at edge DEBOUNCE_CYC+2. The resulting state/field update is visible after edge DEBOUNCE_CYC+3.
- Glitches: a raw pulse shorter than DEBOUNCE_CYC cycles (after sync) produces no pulse.
- FSM: a mode pulse advances RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
- RUN state:
  - Prescaler counts 0..TICKS_PER_SEC-1 and wraps to 0.
  - On the wrap cycle, sec increments. 59 -> 0 carries into min; min 59 -> 0 carries into hour; hour 23 -> 0.
  - 23:59:59 -> 00:00:00 in a single cycle.
  - The INC pulse is ignored.
- SET states:
  - Prescaler is held at 0 and there is no time ticking.
  - An INC pulse increments only the selected field, with wrap and without carry: hour 23->0, min 59->0, sec 59->0.
- SET_SEC -> RUN: the prescaler starts from 0, so the first tick occurs TICKS_PER_SEC cycles after entering RUN.
- Blink:
  - The blink counter counts 0..BLINK_HALF-1 continuously; on wrap, the phase toggles.
  - The counter and phase are cleared to 0 on every mode transition and on every accepted INC pulse, so the field is visible while it is adjusted.
  - blank_mask = phase on the bit of the selected field, 0 elsewhere. blank_mask = 0 in RUN.
  - blank_mask is registered and updates in the same cycle as mode.
- Simultaneous events:
  - MODE and INC pulses in the same cycle: the mode transition wins and INC is dropped.
  - A second tick coinciding with a MODE pulse from RUN: the tick is applied, then the FSM moves to SET_HOUR.
  - Reset overrides everything.
- Outputs never hold illegal values (sec/min <= 59, hour <= 23) in any cycle.

Test Plan (all scenarios use TICKS_PER_SEC=10, DEBOUNCE_CYC=4, BLINK_HALF=3):
- Reset, then hold rst_n=1 for 100 cycles in RUN -> sec=10 at cycle 100, min=hour=0, blank_mask=0. Every sec increment is exactly 10 cycles apart.
- Preload 23:59:59 (via SET mode), return to RUN, wait 10 cycles -> 00:00:00 in one step, with no intermediate values.
- btn_mode high for 3 cycles -> mode remains RUN. btn_mode high for 8 cycles (raw rise at edge 0) -> mode=SET_HOUR after edge 7, and exactly one transition occurs.
- In SET_HOUR with hour=22, give 3 INC presses -> hour 23, 0, 1; min/sec unchanged; prescaler frozen. blank_mask[2] is 0 for 3 cycles after each press, then toggles every 3 cycles.
- btn_mode and btn_inc rising on the same cycle in SET_MIN with min=5 -> mode=SET_SEC, min stays 5, blank_mask=3'b000 immediately.
- Assert rst_n=0 for one cycle mid-debounce in SET_SEC with the counter at 2 -> all outputs return to their reset values on that edge. The held button must then be re-debounced from zero (4 fresh cycles) before any pulse occurs.
